sub_state_engine: RTL
=====================

SUB_STATE_ENGINE -- requirements
Module: sub_state_engine

Interface
REQ-001 The block SHALL have parameter LANES, default 4, meaning S-box lanes used per cycle; legal values are 1, 2, 4, 8 and 16, and any other value SHALL be a elaboration error.
REQ-002 The block SHALL have parameter CYCLES, default 16/LANES, a derived local constant giving the number of BUSY cycles per state.
REQ-003 Port clk: input, 1 bit, the single clock; all state SHALL change on the rising edge.
REQ-004 Port reset_n: input, 1 bit; reset SHALL be asynchronous and active-low.
REQ-005 Port in_valid: input, 1 bit; the upstream stage holds a state.
REQ-006 Port in_ready: output, 1 bit; the block accepts a state this cycle.
REQ-007 Port in_state: input, 128 bits; the AES state.
REQ-008 Port in_inv: input, 1 bit; 0 selects forward SubBytes, 1 selects InvSubBytes.
REQ-009 Port flush: input, 1 bit; synchronous abort.
REQ-010 Port out_valid: output, 1 bit; out_state holds a result.
REQ-011 Port out_ready: input, 1 bit; downstream accepts the result.
REQ-012 Port out_state: output, 128 bits; the substituted state.
REQ-013 Port busy: output, 1 bit; high in the BUSY state.

Function
REQ-014 Byte k, for k = 0..15, SHALL be state[127-8k : 120-8k], so byte 0 is the most significant byte.
REQ-015 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-016 In IDLE, in_ready SHALL be 1; in every other state it SHALL be 0.
REQ-017 When in_valid and in_ready are both 1, the block SHALL:
  - capture in_state into the working register;
  - latch in_inv into a mode register;
  - clear the lane counter to 0;
  - go to BUSY.
REQ-018 In BUSY with counter value c, bytes c*LANES to c*LANES+LANES-1 SHALL be replaced in the working register by the FIPS-197 S-box value (mode 0) or inverse S-box value (mode 1).
REQ-019 Each substitution SHALL be a combinational table lookup, written back on the same edge.
REQ-020 In BUSY, bytes outside the current lane window SHALL hold their value.
REQ-021 The counter SHALL be ceil(log2(CYCLES+1)) bits wide and SHALL increment by 1 per BUSY cycle.
REQ-022 On the edge that processes c = CYCLES-1, the FSM SHALL go to DONE; the counter SHALL NOT wrap.
REQ-023 Latency: out_valid SHALL rise exactly CYCLES clock cycles after the accepting edge (LANES=4: 4 cycles; LANES=16: 1 cycle; LANES=1: 16 cycles).
REQ-024 In DONE, out_valid SHALL be 1 and out_state SHALL equal the working register.
REQ-025 In DONE, out_state SHALL stay stable until out_ready is 1.
REQ-026 When out_valid and out_ready are both 1, the FSM SHALL go to IDLE on that edge.
REQ-027 A new state SHALL be accepted no earlier than the following cycle.
REQ-028 out_state SHALL NOT change outside BUSY or the capture edge.
REQ-029 A change of in_inv or in_state after capture SHALL have no effect on the state in progress.
REQ-030 When flush is 1, on the next edge from any state the block SHALL go to IDLE with the counter at 0 and out_valid at 0; no result SHALL be emitted.
REQ-031 flush SHALL take priority over in_valid and over out_ready in the same cycle.
REQ-032 in_valid in BUSY or DONE SHALL be ignored; the upstream holds the state because in_ready is 0.

Reset
REQ-033 While reset_n is 0, the block SHALL immediately, without a clock edge, drive:
  - state = IDLE;
  - in_ready = 1;
  - out_valid = 0;
  - busy = 0;
  - counter = 0;
  - mode = 0;
  - out_state = 128'h0.
REQ-034 A reset asserted mid-BUSY or in DONE SHALL discard the state in progress.
REQ-035 After reset_n rises, the first acceptance SHALL be possible on the first rising edge.

Verification
REQ-036 Forward case, LANES=4:
  - stimulus: in_state = 00112233445566778899aabbccddeeff, in_inv = 0;
  - response: out_valid rises 4 cycles after acceptance with out_state = 638293c31bfc33f5c4eeacea4bc12816.
REQ-037 Inverse case:
  - stimulus: in_state = 638293c31bfc33f5c4eeacea4bc12816, in_inv = 1;
  - response: out_state = 00112233445566778899aabbccddeeff.
  - repeat for LANES = 1, 2, 8 and 16; latency SHALL be 16, 8, 2 and 1 cycles.
REQ-038 Backpressure case:
  - stimulus: hold out_ready = 0 for 10 cycles in DONE;
  - response: out_valid = 1, out_state stays constant, in_ready = 0 and a new in_valid is ignored;
  - then raise out_ready for 1 cycle: the next cycle is IDLE and in_ready = 1.
REQ-039 Flush case:
  - stimulus: flush = 1 at BUSY counter = 2;
  - response: the next cycle is IDLE, out_valid never asserts, and the next state is processed correctly.
REQ-040 Asynchronous reset case:
  - stimulus: drive reset_n low mid-BUSY, between clock edges;
  - response: busy = 0 and out_state = 0 before the next edge.
REQ-041 Exhaustive case:
  - stimulus: all 256 byte values, 16 per state, in both modes;
  - response: they match the FIPS-197 S-box and inverse S-box, with S(00)=63, S(53)=ed, InvS(63)=00 and InvS(16)=ff.

Source files
------------

// File: rtl/sub_state_engine.sv
// ============================================================================
//  Module   : sub_state_engine
//  Brief    : Multi-cycle AES SubBytes / InvSubBytes engine, LANES bytes/cycle.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sub_state_engine #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int CYCLES = 16 / LANES;
    localparam int CNT_W  = $clog2(CYCLES + 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_state_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [127:0]       r_work;
    logic               r_mode;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic [3:0]         w_idx [LANES];
    logic [7:0]         w_byte[LANES];
    logic [7:0]         w_sub [LANES];

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} >> (8 - n);
        return d[7:0];
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
        logic [7:0] i;
        i = gf_inv(a);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    // Byte k lives at bits [127-8k -: 8]; {~k,3'b000} is that slice's LSB.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_idx[l]  = 4'(32'(r_cnt) * LANES + l);
        assign w_byte[l] = r_work[{~w_idx[l], 3'b000} +: 8];
        assign w_sub[l]  = r_mode ? inv_sbox(w_byte[l]) : fwd_sbox(w_byte[l]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_work      <= 128'h0;
            r_mode      <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_work     <= in_state;
                        r_mode     <= in_inv;
                        r_cnt      <= '0;
                        r_state    <= ST_BUSY;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    for (int l = 0; l < LANES; l++) begin
                        r_work[{~w_idx[l], 3'b000} +: 8] <= w_sub[l];
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(CYCLES - 1)) begin
                        r_state     <= ST_DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= '0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_state = r_work;
    assign busy      = r_busy;

endmodule

`default_nettype wire
